// File: rtl/rambus_pkg.sv
// Shared constants and types for the OpenRAM sample streamer.
//   RAM_ADDR_WIDTH : word-address width of the 1 kB OpenRAM (256 words)
//   BUS_ADDR_WIDTH : byte-address width on the rambus port
//   DATA_WIDTH     : rambus / sample data width
//   fetch_state_e  : fetch FSM encoding
package rambus_pkg;

  localparam int RAM_ADDR_WIDTH = 8;
  localparam int BUS_ADDR_WIDTH = 10;
  localparam int DATA_WIDTH     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/rambus_sample_streamer_if.sv
// Wishbone classic link to port B (rambus) of the dual-port OpenRAM wrapper.
//   master : streamer side (drives clk/rst/cyc/stb/we/sel/dat_o/adr, reads ack/dat_i)
//   slave  : RAM wrapper side
interface rambus_sample_streamer_if;

  logic                                rambus_wb_clk_o;
  logic                                rambus_wb_rst_o;
  logic                                rambus_wb_stb_o;
  logic                                rambus_wb_cyc_o;
  logic                                rambus_wb_we_o;
  logic [3:0]                          rambus_wb_sel_o;
  logic [rambus_pkg::DATA_WIDTH-1:0]     rambus_wb_dat_o;
  logic [rambus_pkg::BUS_ADDR_WIDTH-1:0] rambus_wb_adr_o;
  logic                                rambus_wb_ack_i;
  logic [rambus_pkg::DATA_WIDTH-1:0]     rambus_wb_dat_i;

  modport master (
    output rambus_wb_clk_o, rambus_wb_rst_o, rambus_wb_stb_o, rambus_wb_cyc_o,
           rambus_wb_we_o, rambus_wb_sel_o, rambus_wb_dat_o, rambus_wb_adr_o,
    input  rambus_wb_ack_i, rambus_wb_dat_i
  );

  modport slave (
    input  rambus_wb_clk_o, rambus_wb_rst_o, rambus_wb_stb_o, rambus_wb_cyc_o,
           rambus_wb_we_o, rambus_wb_sel_o, rambus_wb_dat_o, rambus_wb_adr_o,
    output rambus_wb_ack_i, rambus_wb_dat_i
  );

endinterface

// File: rtl/stream_fifo.sv
// Small synchronous FIFO decoupling the RAM fetch side from the play side.
//   clk, rst_n      : clock, async active-low reset
//   flush           : empties the FIFO (wins over push/pop)
//   push, push_data : write one entry (never issued when full without a pop)
//   pop, pop_data   : pop_data is the head entry, pop removes it
//   full, empty     : occupancy flags
//   count           : number of valid entries
module stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      // push+pop together (also legal when full) leaves the count unchanged
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/rambus_sample_streamer.sv
// Cyclic OpenRAM window reader feeding a periodic sample output (DAC path).
//   wb_clk_i, wb_rst_n_i : clock, async active-low reset
//   rambus               : Wishbone classic master on the OpenRAM rambus port
//   enable_i             : run; low aborts the fetch, flushes the FIFO, stops the period counter
//   start_addr_i/length_i: window first word / length in words (0 means 256)
//   period_i             : sample interval is period_i+1 cycles
//   sample_o/sample_valid_o : held sample and its one-cycle update pulse
//   underrun_o, bus_err_o   : sticky flags, cleared on reset or enable rising edge
//   busy_o               : fetch FSM not IDLE
//
// Fetch FSM
//   state | meaning
//   IDLE  | no cycle on the bus; start a read when enabled and the FIFO has room
//   REQ   | read cycle in progress; ack pushes data, watchdog aborts
//   DRAIN | enable dropped mid-read; hold the cycle until ack/watchdog, discard data
module rambus_sample_streamer
  import rambus_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int PERIOD_WIDTH = 16,
  parameter int WDOG_CYCLES  = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_n_i,
  rambus_sample_streamer_if.master  rambus,
  input  logic                      enable_i,
  input  logic [RAM_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [RAM_ADDR_WIDTH:0]   length_i,
  input  logic [PERIOD_WIDTH-1:0]   period_i,
  output logic [DATA_WIDTH-1:0]     sample_o,
  output logic                      sample_valid_o,
  output logic                      underrun_o,
  output logic                      bus_err_o,
  output logic                      busy_o
);

  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [WDOG_W-1:0] WDOG_LOAD = WDOG_W'(WDOG_CYCLES - 1);

  fetch_state_e              state_q, state_d;
  logic                      cyc_q, cyc_d;
  logic [RAM_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [RAM_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                      load_q, load_d;
  logic [WDOG_W-1:0]         wdog_q, wdog_d;
  logic [PERIOD_WIDTH-1:0]   per_q, per_d;
  logic [DATA_WIDTH-1:0]     sample_q, sample_d;
  logic                      valid_q, valid_d;
  logic                      underrun_q, underrun_d;
  logic                      bus_err_q, bus_err_d;
  logic                      en_q;

  logic                      en_rise;
  logic [RAM_ADDR_WIDTH:0]   len_m1;
  logic                      push, pop, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0]     fifo_head;
  logic [CNT_W-1:0]          fifo_count;

  assign en_rise = enable_i & ~en_q;
  assign len_m1  = (length_i == '0) ? (RAM_ADDR_WIDTH+1)'(255) : length_i - 1'b1;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    load_d     = load_q | en_rise;
    wdog_d     = wdog_q;
    per_d      = per_q;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    underrun_d = en_rise ? 1'b0 : underrun_q;
    bus_err_d  = en_rise ? 1'b0 : bus_err_q;
    push       = 1'b0;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable_i && !fifo_full) begin
          state_d = REQ;
          cyc_d   = 1'b1;
          wdog_d  = WDOG_LOAD;
          // window restarts only on the first read after enable rises
          if (load_q || en_rise) begin
            ptr_d  = start_addr_i;
            cnt_d  = '0;
            load_d = 1'b0;
          end
        end
      end
      REQ: begin
        if (rambus.rambus_wb_ack_i) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
          if (enable_i) begin
            push = 1'b1;
            if ({1'b0, cnt_q} == len_m1) begin
              ptr_d = start_addr_i;
              cnt_d = '0;
            end else begin
              ptr_d = ptr_q + 1'b1;
              cnt_d = cnt_q + 1'b1;
            end
          end
        end else if (wdog_q == '0) begin
          state_d   = IDLE;
          cyc_d     = 1'b0;
          bus_err_d = 1'b1;
        end else begin
          wdog_d = wdog_q - 1'b1;
          if (!enable_i) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (rambus.rambus_wb_ack_i) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
        end else if (wdog_q == '0) begin
          state_d   = IDLE;
          cyc_d     = 1'b0;
          bus_err_d = 1'b1;
        end else begin
          wdog_d = wdog_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase

    // >= keeps the tick alive if period_i shrinks below the running count
    if (!enable_i) begin
      per_d = '0;
    end else if (per_q >= period_i) begin
      per_d = '0;
      if (!fifo_empty) begin
        pop      = 1'b1;
        sample_d = fifo_head;
        valid_d  = 1'b1;
      end else begin
        underrun_d = 1'b1;
      end
    end else begin
      per_d = per_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= IDLE;
      cyc_q      <= 1'b0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      load_q     <= 1'b0;
      wdog_q     <= '0;
      per_q      <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      bus_err_q  <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      load_q     <= load_d;
      wdog_q     <= wdog_d;
      per_q      <= per_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
      bus_err_q  <= bus_err_d;
      en_q       <= enable_i;
    end
  end

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n_i),
    .flush     (~enable_i),
    .push      (push),
    .push_data (rambus.rambus_wb_dat_i),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rambus.rambus_wb_clk_o = wb_clk_i;
  assign rambus.rambus_wb_rst_o = ~wb_rst_n_i;
  assign rambus.rambus_wb_cyc_o = cyc_q;
  assign rambus.rambus_wb_stb_o = cyc_q;
  assign rambus.rambus_wb_we_o  = 1'b0;
  assign rambus.rambus_wb_sel_o = 4'hF;
  assign rambus.rambus_wb_dat_o = '0;
  assign rambus.rambus_wb_adr_o = {ptr_q, 2'b00};

  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign underrun_o     = underrun_q;
  assign bus_err_o      = bus_err_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: doc/rambus_sample_streamer.md
Name: rambus_sample_streamer

Overview:
- Wishbone classic master on the rambus port (port B) of the dual-port OpenRAM wrapper.
- Cyclically reads a programmable window of 32-bit words from the 1 kB OpenRAM into a small FIFO.
- Pops one sample per programmable period to a downstream sample consumer (function-generator DAC path).
- Fetch side and play side are decoupled by the FIFO; a bus watchdog guards against a missing ack.

Parameters:
- RAM_ADDR_WIDTH, 8, word-address width (256 words); bus address is {word, 2'b00}, 10 bits
- FIFO_DEPTH, 4, sample FIFO entries (power of two, >=2)
- PERIOD_WIDTH, 16, width of the sample-period divider
- WDOG_CYCLES, 255, max cycles to wait for ack before aborting a read

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_n_i  in  1  asynchronous, active-low reset
- enable_i  in  1  run when high; falling edge aborts and flushes
- start_addr_i  in  8  first word of the window
- length_i  in  9  window length in words, 1..256; 0 is treated as 256
- period_i  in  PERIOD_WIDTH  sample interval = period_i+1 cycles
- rambus_wb_clk_o  out  1  = wb_clk_i
- rambus_wb_rst_o  out  1  = ~wb_rst_n_i
- rambus_wb_stb_o / rambus_wb_cyc_o  out  1  strobe/cycle, always equal
- rambus_wb_we_o  out  1  constant 0
- rambus_wb_sel_o  out  4  constant 4'hF
- rambus_wb_dat_o  out  32  constant 0
- rambus_wb_adr_o  out  10  byte address {word_ptr, 2'b00}
- rambus_wb_ack_i  in  1  read ack
- rambus_wb_dat_i  in  32  read data
- sample_o  out  32  current sample, held between ticks
- sample_valid_o  out  1  one-cycle pulse when sample_o updates
- underrun_o  out  1  sticky: a tick found the FIFO empty
- bus_err_o  out  1  sticky: watchdog expired
- busy_o  out  1  fetch FSM not IDLE

Behaviour:
- Reset: all outputs 0 (rambus_wb_sel_o = 4'hF, rambus_wb_rst_o = 1); FIFO empty; FSM IDLE; pointers and counters 0.
- Fetch FSM states: IDLE, REQ, DRAIN.
- IDLE -> REQ when enable_i=1 and FIFO has a free slot.
  - On entry, word_ptr loads start_addr_i (first entry only after enable rises) and the word counter is cleared.
- REQ: cyc/stb high, address stable.
  - On ack: push rambus_wb_dat_i into the FIFO and drop cyc/stb for one cycle (return to IDLE).
  - Advance word_ptr; when the counter reaches length-1, reload start_addr_i and clear the counter (window wrap).
  - word_ptr arithmetic is mod 256; a window crossing word 255 wraps to word 0.
- Watchdog: REQ held for WDOG_CYCLES without ack -> drop cyc/stb, set bus_err_o, go IDLE, no push, pointer not advanced (same word retried).
- enable_i low:
  - From REQ -> DRAIN. DRAIN keeps cyc/stb high until ack or watchdog, discards the data, then goes IDLE.
  - FIFO is flushed the cycle enable_i is seen low.
  - Period counter is cleared.
  - sample_o holds its last value.
- Play side: the period counter runs only while enable_i=1 and counts 0..period_i.
  - Tick at terminal count, i.e. first tick period_i+1 cycles after enable rises.
  - Tick with FIFO non-empty: pop, sample_o <= head, sample_valid_o=1 next cycle.
  - Tick with FIFO empty: underrun_o <= 1, sample_o unchanged, no pulse.
  - period_i=0 gives a tick every cycle.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Push is never attempted when full: REQ is only entered with a free slot.
- Sticky flags clear only on reset or on an enable_i rising edge.
- Latency: first sample_valid_o no earlier than the first tick, and only if a read has completed.

Decomposition:
- Package rambus_pkg: RAM_ADDR_WIDTH, bus address width 10, data width 32, FSM state enum {IDLE, REQ, DRAIN}.
- Sub-module stream_fifo: synchronous FIFO, parameters DEPTH and WIDTH, ports push/pop/full/empty/count, async active-low reset, flush input.

Test Plan:
- Window start=0x10, length=3, period=3, memory word n = n, ack after 1 cycle -> sample_o sequence 0x10, 0x11, 0x12, 0x10, ... with sample_valid_o every 4 cycles; addresses 0x040, 0x044, 0x048.
- start=0xFE, length=4 -> words fetched 0xFE, 0xFF, 0x00, 0x01, then 0xFE again.
- period=0 with ack delay 3 cycles -> underrun_o set; samples still emitted in order with no duplicates or skips.
- Ack never returned -> cyc/stb drops after 255 cycles, bus_err_o=1, retry issued to the same address.
- enable_i low while REQ is pending -> cyc/stb held until ack, data discarded, FIFO empty, no sample_valid_o afterwards; re-enable restarts at start_addr_i with flags cleared.
- Async reset asserted mid-read -> all outputs at reset values immediately, without waiting for a clock edge.
